// File: rtl/mm_bus_read.sv
// Register-bank read stage for the motor-move engine: snapshots the four enable
// registers plus per-row step and sleep counts of one column through a single read port.
module mm_bus_read #(
  parameter int ROWS        = 29,
  parameter int COL_W       = 2,
  parameter int ROW_W       = 5,
  parameter int REG_W       = 4,
  parameter int DATA_W      = 16,
  parameter int STEPS_REG   = 0,
  parameter int SLEEPS_REG  = 1,
  parameter int ENABLE_REG0 = 8,
  parameter logic [ROW_W-1:0] CTRL_ROW = '1,
  parameter logic [COL_W-1:0] CTRL_COL = '1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [COL_W-1:0]              col,
  input  logic                          abort,
  output logic                          rd_req,
  output logic [ROW_W+COL_W+REG_W-1:0]  rd_addr,
  input  logic                          rd_gnt,
  input  logic                          rd_valid,
  input  logic [DATA_W-1:0]             rd_data,
  output logic [4*DATA_W-1:0]           enables,
  output logic [ROWS*DATA_W-1:0]        num_steps,
  output logic [ROWS*DATA_W-1:0]        num_sleeps,
  output logic                          busy,
  output logic                          done
);

  localparam int ADDR_W = ROW_W + COL_W + REG_W;
  // idx must also count the four enable registers when ROW_W is tiny
  localparam int IDX_W  = (ROW_W > 2) ? ROW_W : 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_EN     = 3'd1,
    RD_STEPS  = 3'd2,
    RD_SLEEPS = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic               wait_reg, wait_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [COL_W-1:0]   col_reg, col_next;

  logic               reading;
  logic               last_idx;
  logic               capture;
  logic [REG_W-1:0]   en_sel;

  assign reading  = (state_reg == RD_EN) || (state_reg == RD_STEPS) || (state_reg == RD_SLEEPS);
  assign last_idx = (state_reg == RD_EN) ? (idx_reg == IDX_W'(3)) : (idx_reg == IDX_W'(ROWS - 1));
  // abort wins over a coincident rd_valid, so the arrays keep only completed reads
  assign capture  = reading && wait_reg && rd_valid && !abort;
  assign en_sel   = REG_W'(ENABLE_REG0) + REG_W'(idx_reg);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      wait_reg  <= 1'b0;
      idx_reg   <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      idx_reg   <= idx_next;
      col_reg   <= col_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    idx_next   = idx_reg;
    col_next   = col_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RD_EN;
          col_next   = col;
          idx_next   = '0;
          wait_next  = 1'b0;
        end
      end
      RD_EN, RD_STEPS, RD_SLEEPS: begin
        if (!wait_reg) begin
          if (rd_gnt) begin
            wait_next = 1'b1;
          end
        end else if (rd_valid) begin
          wait_next = 1'b0;
          if (last_idx) begin
            idx_next = '0;
            case (state_reg)
              RD_EN:    state_next = RD_STEPS;
              RD_STEPS: state_next = RD_SLEEPS;
              default:  state_next = DONE;
            endcase
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        wait_next  = 1'b0;
        idx_next   = '0;
      end
    endcase
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      wait_next  = 1'b0;
      idx_next   = '0;
    end
  end

  // Output logic
  always_comb begin
    rd_req  = reading && !wait_reg;
    rd_addr = '0;
    if (rd_req) begin
      case (state_reg)
        RD_EN:     rd_addr = {CTRL_ROW, CTRL_COL, en_sel};
        RD_STEPS:  rd_addr = {idx_reg[ROW_W-1:0], col_reg, REG_W'(STEPS_REG)};
        RD_SLEEPS: rd_addr = {idx_reg[ROW_W-1:0], col_reg, REG_W'(SLEEPS_REG)};
        default:   rd_addr = ADDR_W'(0);
      endcase
    end
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  // Snapshot arrays: each slot only loads when its own index is being captured
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_en
      logic [DATA_W-1:0] en_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          en_reg <= '0;
        end else if (capture && (state_reg == RD_EN) && (idx_reg == IDX_W'(gi))) begin
          en_reg <= rd_data;
        end
      end
      assign enables[gi*DATA_W +: DATA_W] = en_reg;
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [DATA_W-1:0] steps_reg;
      logic [DATA_W-1:0] sleeps_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          steps_reg <= '0;
        end else if (capture && (state_reg == RD_STEPS) && (idx_reg == IDX_W'(gi))) begin
          steps_reg <= rd_data;
        end
      end
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sleeps_reg <= '0;
        end else if (capture && (state_reg == RD_SLEEPS) && (idx_reg == IDX_W'(gi))) begin
          sleeps_reg <= rd_data;
        end
      end
      assign num_steps[gi*DATA_W +: DATA_W]  = steps_reg;
      assign num_sleeps[gi*DATA_W +: DATA_W] = sleeps_reg;
    end
  endgenerate

endmodule

// File: tb/tb_mm_bus_read.sv
// Directed bench for mm_bus_read with ROWS=4 and a bank model returning {salt, row, reg}.
module tb_mm_bus_read;

  localparam int ROWS = 4;
  localparam int AW   = 11;
  localparam int DW   = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [1:0]         col;
  logic               abort;
  logic               rd_req;
  logic [AW-1:0]      rd_addr;
  logic               rd_gnt;
  logic               rd_valid = 1'b0;
  logic [DW-1:0]      rd_data = '0;
  logic [4*DW-1:0]    enables;
  logic [ROWS*DW-1:0] num_steps;
  logic [ROWS*DW-1:0] num_sleeps;
  logic               busy;
  logic               done;

  int total = 0;
  int bad   = 0;

  logic [6:0]    salt = 7'h11;
  bit            stall_mode = 1'b0;
  bit            stray = 1'b0;
  int            stall_cnt = 0;
  logic [AW-1:0] log_q[$];

  mm_bus_read #(.ROWS(ROWS)) dut (
    .clock(clock), .reset(reset), .start(start), .col(col), .abort(abort),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .enables(enables), .num_steps(num_steps),
    .num_sleeps(num_sleeps), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] bank_data(logic [AW-1:0] a, logic [6:0] s);
    return {s, a[10:6], a[3:0]};
  endfunction

  function automatic logic [AW-1:0] mk_addr(logic [4:0] r, logic [1:0] c, logic [3:0] g);
    return {r, c, g};
  endfunction

  // Bank: grants whenever no stall is pending, returns data one cycle after grant
  assign rd_gnt = rd_req && (stall_cnt == 0);

  always @(posedge clock) begin
    rd_valid <= stray;
    if (rd_req && rd_gnt) begin
      rd_valid  <= 1'b1;
      rd_data   <= bank_data(rd_addr, salt);
      log_q.push_back(rd_addr);
      stall_cnt <= stall_mode ? int'($urandom_range(0, 5)) : 0;
    end else if (rd_req && stall_cnt != 0) begin
      stall_cnt <= stall_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_req"}, 64'(rd_req), 64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_enables"}, 64'(enables), 64'd0);
    chk({tag, "_steps"}, 64'(num_steps), 64'd0);
    chk({tag, "_sleeps"}, 64'(num_sleeps), 64'd0);
  endtask

  task automatic check_log(input logic [1:0] c);
    logic [AW-1:0] exp_a;
    chk("log_count", 64'(log_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < log_q.size(); i++) begin
      if (i < 4)      exp_a = mk_addr(5'h1F, 2'b11, 4'(8 + i));
      else if (i < 8) exp_a = mk_addr(5'(i - 4), c, 4'd0);
      else            exp_a = mk_addr(5'(i - 8), c, 4'd1);
      chk($sformatf("log_addr%0d", i), 64'(log_q[i]), 64'(exp_a));
    end
  endtask

  task automatic check_arrays(input logic [1:0] c, input logic [6:0] s);
    for (int k = 0; k < 4; k++)
      chk($sformatf("enables%0d", k), 64'(enables[k*DW +: DW]),
          64'(bank_data(mk_addr(5'h1F, 2'b11, 4'(8 + k)), s)));
    for (int r = 0; r < ROWS; r++) begin
      chk($sformatf("steps%0d", r), 64'(num_steps[r*DW +: DW]),
          64'(bank_data(mk_addr(5'(r), c, 4'd0), s)));
      chk($sformatf("sleeps%0d", r), 64'(num_sleeps[r*DW +: DW]),
          64'(bank_data(mk_addr(5'(r), c, 4'd1), s)));
    end
  endtask

  // Called just after a negedge; returns start-to-done latency and stall cycles.
  task automatic run_load(input logic [1:0] c, input bit extra_starts,
                          output int lat, output int stalls);
    bit            got = 1'b0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    int            dones = 0;
    log_q.delete();
    lat = 0;
    stalls = 0;
    start = 1'b1;
    col = c;
    for (int cyc = 1; cyc <= 400 && !got; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (extra_starts && (cyc == 5 || cyc == 15)) begin
        start = 1'b1;
        col = 2'd1;
      end
      if (prev_stall) begin
        chk("stall_req_held", 64'(rd_req), 64'd1);
        chk("stall_addr_held", 64'(rd_addr), 64'(prev_addr));
      end
      prev_stall = rd_req && !rd_gnt;
      prev_addr = rd_addr;
      if (prev_stall) stalls++;
      if (done) begin
        got = 1'b1;
        lat = cyc;
        dones++;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    @(negedge clock);
    chk("busy_after_done", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      if (done) dones++;
      @(negedge clock);
    end
    chk("done_pulses", 64'(dones), 64'd1);
    check_log(c);
  endtask

  int lat, stalls;
  bit found;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    col   = 2'd0;
    abort = 1'b0;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Zero-wait load of column 2
    run_load(2'd2, 1'b0, lat, stalls);
    $display("load col=2 zero-wait: latency=%0d stalls=%0d", lat, stalls);
    chk("zero_wait_latency", 64'(lat), 64'd25);
    chk("zero_wait_stalls", 64'(stalls), 64'd0);
    check_arrays(2'd2, 7'h11);
    chk("steps3_model", 64'(num_steps[3*DW +: DW]), 64'h2230);

    // Random stalls plus ignored start pulses, same bank contents
    stall_mode = 1'b1;
    run_load(2'd2, 1'b1, lat, stalls);
    stall_mode = 1'b0;
    $display("load col=2 stalled: latency=%0d stalls=%0d", lat, stalls);
    chk("stall_latency", 64'(lat), 64'(25 + stalls));
    check_arrays(2'd2, 7'h11);

    // Abort while requesting num_steps row 2
    salt = 7'h22;
    log_q.delete();
    start = 1'b1;
    col = 2'd2;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (rd_req && log_q.size() == 6) found = 1'b1;
      else @(negedge clock);
    end
    chk("abort_point_reached", 64'(found), 64'd1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    $display("abort during RD_STEPS idx=2: busy=%0d done=%0d", busy, done);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_inflight_valid", 64'(rd_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_no_req", 64'(rd_req), 64'd0);
    end
    stray = 1'b1;
    @(negedge clock);
    stray = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 4; k++)
      chk($sformatf("abort_enables%0d", k), 64'(enables[k*DW +: DW]),
          64'(bank_data(mk_addr(5'h1F, 2'b11, 4'(8 + k)), 7'h22)));
    for (int r = 0; r < ROWS; r++) begin
      chk($sformatf("abort_steps%0d", r), 64'(num_steps[r*DW +: DW]),
          64'(bank_data(mk_addr(5'(r), 2'd2, 4'd0), (r < 2) ? 7'h22 : 7'h11)));
      chk($sformatf("abort_sleeps%0d", r), 64'(num_sleeps[r*DW +: DW]),
          64'(bank_data(mk_addr(5'(r), 2'd2, 4'd1), 7'h11)));
    end

    // Asynchronous reset in RD_SLEEPS, then a fresh load of column 1
    salt = 7'h33;
    log_q.delete();
    start = 1'b1;
    col = 2'd1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (log_q.size() >= 9) found = 1'b1;
      else @(negedge clock);
    end
    chk("sleeps_point_reached", 64'(found), 64'd1);
    chk("busy_before_reset", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    $display("async reset in RD_SLEEPS: busy=%0d enables=%0h", busy, enables);
    check_outputs_zero("async_reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_load(2'd1, 1'b0, lat, stalls);
    $display("load col=1 after reset: latency=%0d stalls=%0d", lat, stalls);
    chk("fresh_latency", 64'(lat), 64'd25);
    check_arrays(2'd1, 7'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
